mioc_gate_pattern_seq: RTL and testbench
========================================

Name: mioc_gate_pattern_seq

Overview:
Hardware pattern sequencer and response checker for MIOC single-gate ASIC test structures, with N_IN inputs and one output (default target: 2-input XNOR).
- Upstream side: drives every input combination onto the gate inputs.
- Downstream side: waits a settle time, then samples and synchronises the gate output and compares it against a parameterised truth table.
- Reports a per-pattern log strobe, a mismatch count and a final pass/fail.
- Replaces file-driven pattern application when the test runs on-chip or on an FPGA.

Parameters:
N_IN, 2, number of gate inputs; patterns run 0 .. 2^N_IN-1.
SETTLE_CYCLES, 8, clk cycles between applying a pattern and sampling; must be >= 3 (covers the 2-flop synchroniser); elaboration error otherwise.
TRUTH_TABLE, 4'b1001, expected z indexed by pattern value, width 2^N_IN; the default is XNOR2.
ERR_W, 4, width of the mismatch counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE or DONE
dut_z  in  1  gate output, asynchronous to clk
dut_in  out  N_IN  registered gate input drive; bit 0 = in2/LSB, bit 1 = in1
busy  out  1  high in SETTLE and SAMPLE
done  out  1  high in DONE, held until next start or reset
pass  out  1  done && err_count==0, held with done
err_count  out  ERR_W  saturating mismatch count for the current run
sample_valid  out  1  one-cycle strobe per pattern
sample_pat  out  N_IN  pattern sampled, valid with sample_valid
sample_z  out  1  synchronised z sampled, valid with sample_valid
sample_err  out  1  sample_z != TRUTH_TABLE[sample_pat], valid with sample_valid

Behaviour:
Reset
- rst_n low: immediate and asynchronous.
- All outputs go to 0: dut_in=0, busy/done/pass/err_count/sample_* = 0.
- Synchroniser flops go to 0; state goes to IDLE.
- Reset mid-run abandons the run; there is no partial done.

Synchroniser
- dut_z passes through a 2-flop synchroniser (z_s).
- Only z_s is observed.

State machine: IDLE, SETTLE, SAMPLE, DONE
- IDLE or DONE, start=1: pat=0, dut_in=0, err_count=0, done=0, pass=0, cnt=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: cnt decrements each cycle; at cnt==0 go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - sample_valid=1, sample_pat=pat, sample_z=z_s, sample_err = z_s ^ TRUTH_TABLE[pat].
  - If sample_err: err_count increments, saturating at 2^ERR_W-1.
  - If pat == 2^N_IN-1: go to DONE, with done=1 and pass=(final err_count==0) visible in the first DONE cycle.
  - Otherwise: pat+1 is driven on dut_in, cnt is reloaded, go to SETTLE.

Timing
- dut_in changes only on SAMPLE->SETTLE and on start; it is stable across each SETTLE window.
- Each pattern costs SETTLE_CYCLES+1 cycles.
- With start seen at edge k, done rises at edge k+1+2^N_IN*(SETTLE_CYCLES+1). Defaults: k+37.
- sample_* outputs are registered; all except sample_valid hold their last value between strobes.

Boundary conditions
- start while busy: ignored.
- start in the same cycle as the final SAMPLE: ignored (state is not IDLE/DONE).
- start in DONE: restarts immediately and clears done/pass in the next cycle.
- Pattern counter does not wrap; the terminal test is on 2^N_IN-1.
- N_IN=1 must work (2 patterns).

Decomposition:
- Shared include/package mioc_test_pkg: state encodings (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and the standard truth-table constants (TT_XNOR2=4'b1001, TT_NAND2=4'b0111, TT_NOR2=4'b0001, TT_INV=2'b01).
- One sub-module, mioc_sync2: 2-flop synchroniser with clk and rst_n, reset value 0. It is reused by the other MIOC gate sequencers.

Test Plan:
- Behavioural XNOR2 model on dut_in/dut_z, start pulse -> sample strobes (pat,z) = (0,1),(1,0),(2,0),(3,1); sample_err all 0; done at start+37 cycles; pass=1; err_count=0.
- DUT z stuck at 0 -> sample_err on patterns 0 and 3; err_count=2; pass=0; done still at start+37.
- Check dut_in against strobe timing -> dut_in==sample_pat at every strobe; dut_in constant during all 8 SETTLE cycles of each pattern.
- rst_n low during SETTLE of pattern 2, then released and start pulsed -> outputs all 0 immediately at assertion; new run begins at pattern 0 with err_count=0 and completes with pass=1.
- start pulsed while busy, and again in DONE -> busy-time start has no effect on the sequence; DONE-time start clears done/pass next cycle and reruns.
- ERR_W=1, DUT z inverted -> all 4 strobes show sample_err=1; err_count saturates at 1; pass=0.

Source files
------------

// File: rtl/mioc_test_pkg.sv
// Shared definitions for the MIOC single-gate pattern sequencers:
// FSM state encodings and the standard gate truth tables.
package mioc_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Truth tables are indexed by the input pattern value (bit 0 = LSB input).
   localparam logic [3:0] TT_XNOR2 = 4'b1001;
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_NOR2  = 4'b0001;
   localparam logic [1:0] TT_INV   = 2'b01;

endpackage

// File: rtl/mioc_gate_pattern_seq_if.sv
// Pattern sequencer bus: gate drive/observe plus run status and per-pattern log.
interface mioc_gate_pattern_seq_if #(
   parameter int N_IN  = 2,
   parameter int ERR_W = 4
);
   logic             start;
   logic             dut_z;
   logic [N_IN-1:0]  dut_in;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic             sample_valid;
   logic [N_IN-1:0]  sample_pat;
   logic             sample_z;
   logic             sample_err;

   modport master (
      output start, dut_z,
      input  dut_in, busy, done, pass, err_count,
             sample_valid, sample_pat, sample_z, sample_err
   );

   modport slave (
      input  start, dut_z,
      output dut_in, busy, done, pass, err_count,
             sample_valid, sample_pat, sample_z, sample_err
   );
endinterface

// File: rtl/mioc_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 0.
module mioc_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic ff1_q, ff2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1_q <= 1'b0;
         ff2_q <= 1'b0;
      end else begin
         ff1_q <= d_i;
         ff2_q <= ff1_q;
      end
   end

   assign q_o = ff2_q;
endmodule

// File: rtl/mioc_gate_pattern_seq.sv
// Walks every input pattern of a single-gate test structure, samples the
// synchronised gate output after a settle window and checks it against a truth table.
module mioc_gate_pattern_seq
   import mioc_test_pkg::*;
#(
   parameter int                  N_IN          = 2,
   parameter int                  SETTLE_CYCLES = 8,
   parameter logic [2**N_IN-1:0]  TRUTH_TABLE   = TT_XNOR2,
   parameter int                  ERR_W         = 4
) (
   input logic                clk,
   input logic                rst_n,
   mioc_gate_pattern_seq_if.slave bus
);
   localparam int                CW      = $clog2(SETTLE_CYCLES + 1);
   localparam logic [N_IN-1:0]   PAT_MAX = {N_IN{1'b1}};
   localparam logic [ERR_W-1:0]  ERR_MAX = {ERR_W{1'b1}};
   localparam logic [CW-1:0]     CNT_LD  = CW'(SETTLE_CYCLES - 1);

   // The synchroniser eats two of the settle cycles, so shorter windows sample stale z.
   if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("mioc_gate_pattern_seq: SETTLE_CYCLES must be >= 3");
   end

   state_e            state_q;
   logic [N_IN-1:0]   pat_q;
   logic [CW-1:0]     cnt_q;
   logic              busy_q, done_q, pass_q;
   logic [ERR_W-1:0]  err_q;
   logic              sv_q, sz_q, serr_q;
   logic [N_IN-1:0]   spat_q;
   logic              z_s;
   logic              samp_err;

   mioc_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.dut_z),
      .q_o   (z_s)
   );

   assign samp_err = z_s ^ TRUTH_TABLE[pat_q];

   // Sample results are registered on entry to SAMPLE so the strobe coincides
   // with the pattern still on dut_in and the updated error count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         sv_q    <= 1'b0;
         spat_q  <= '0;
         sz_q    <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         sv_q <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  pat_q   <= '0;
                  err_q   <= '0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  cnt_q   <= CNT_LD;
                  state_q <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= ST_SAMPLE;
                  sv_q    <= 1'b1;
                  spat_q  <= pat_q;
                  sz_q    <= z_s;
                  serr_q  <= samp_err;
                  if (samp_err && err_q != ERR_MAX) err_q <= err_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (pat_q == PAT_MAX) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == '0);
               end else begin
                  pat_q   <= pat_q + 1'b1;
                  cnt_q   <= CNT_LD;
                  state_q <= ST_SETTLE;
               end
            end
         endcase
      end
   end

   assign bus.dut_in       = pat_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.pass         = pass_q;
   assign bus.err_count    = err_q;
   assign bus.sample_valid = sv_q;
   assign bus.sample_pat   = spat_q;
   assign bus.sample_z     = sz_q;
   assign bus.sample_err   = serr_q;
endmodule

// File: tb/tb_mioc_gate_pattern_seq.sv
// Bench for mioc_gate_pattern_seq: behavioural gates with random fault functions,
// checked against a pattern-walk reference model on three parameterisations.
module tb_mioc_gate_pattern_seq;
   import mioc_test_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Gate functions seen by each instance: z = gate[dut_in].
   logic [3:0] gate_a, gate_b;
   logic [1:0] gate_c;
   logic [3:0] spec_a = 4'b1001;
   logic [1:0] spec_c = 2'b01;

   mioc_gate_pattern_seq_if #(.N_IN(2), .ERR_W(4)) ifa ();
   mioc_gate_pattern_seq_if #(.N_IN(2), .ERR_W(1)) ifb ();
   mioc_gate_pattern_seq_if #(.N_IN(1), .ERR_W(2)) ifc ();

   assign ifa.dut_z = gate_a[ifa.dut_in];
   assign ifb.dut_z = gate_b[ifb.dut_in];
   assign ifc.dut_z = gate_c[ifc.dut_in];

   mioc_gate_pattern_seq u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

   mioc_gate_pattern_seq #(.N_IN(2), .SETTLE_CYCLES(3), .ERR_W(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   mioc_gate_pattern_seq #(.N_IN(1), .SETTLE_CYCLES(3), .TRUTH_TABLE(TT_INV), .ERR_W(2)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .bus(ifc));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   // Full run on instance A. done_edge counts clock edges from the edge that
   // accepted start to the first edge that sees done high.
   task automatic run_a(input logic [3:0] g, input int busy_e, input bit late_start, input int abort_e);
      int idx = 0;
      int done_edge = 0;
      int nerr_exp;
      gate_a = g;
      nerr_exp = sat($countones(g ^ spec_a), 15);
      @(negedge clk); ifa.start = 1'b1;
      @(negedge clk); ifa.start = 1'b0;
      chk("a_start_busy", ifa.busy, 1);
      chk("a_start_clr", {ifa.done, ifa.pass, ifa.err_count, ifa.dut_in}, 0);
      for (int e = 1; e <= 200 && done_edge == 0; e++) begin
         @(negedge clk);
         ifa.start = 1'b0;
         if (e == abort_e) begin
            chk("a_abort_pat", ifa.dut_in, 2);
            rst_n = 1'b0;
            #1;
            chk("a_abort_rst", {ifa.dut_in, ifa.busy, ifa.done, ifa.pass, ifa.err_count,
                                ifa.sample_valid, ifa.sample_pat, ifa.sample_z, ifa.sample_err}, 0);
            return;
         end
         if (ifa.sample_valid) begin
            chk("a_spat", ifa.sample_pat, idx);
            chk("a_din_strobe", ifa.dut_in, idx);
            chk("a_sz", ifa.sample_z, g[idx[1:0]]);
            chk("a_serr", ifa.sample_err, g[idx[1:0]] ^ spec_a[idx[1:0]]);
            if (late_start && idx == 3) ifa.start = 1'b1;
            idx++;
         end else if (ifa.busy) begin
            chk("a_din_hold", ifa.dut_in, idx);
         end
         if (e == busy_e) ifa.start = 1'b1;
         if (ifa.done) done_edge = e + 1;
      end
      chk("a_done_edge", done_edge, 1 + 4 * (8 + 1));
      chk("a_strobes", idx, 4);
      chk("a_err_count", ifa.err_count, nerr_exp);
      chk("a_pass", ifa.pass, (nerr_exp == 0) ? 1 : 0);
      @(negedge clk);
      chk("a_done_hold", {ifa.done, ifa.busy, ifa.sample_valid, ifa.sample_pat}, {1'b1, 1'b0, 1'b0, 2'd3});
   endtask

   task automatic run_b(input logic [3:0] g);
      int idx = 0;
      int done_edge = 0;
      int nerr = $countones(g ^ spec_a);
      gate_b = g;
      @(negedge clk); ifb.start = 1'b1;
      @(negedge clk); ifb.start = 1'b0;
      for (int e = 1; e <= 100 && done_edge == 0; e++) begin
         @(negedge clk);
         if (ifb.sample_valid) begin
            chk("b_serr", ifb.sample_err, g[idx[1:0]] ^ spec_a[idx[1:0]]);
            idx++;
         end
         if (ifb.done) done_edge = e + 1;
      end
      chk("b_done_edge", done_edge, 1 + 4 * (3 + 1));
      chk("b_strobes", idx, 4);
      chk("b_err_sat", ifb.err_count, sat(nerr, 1));
      chk("b_pass", ifb.pass, (nerr == 0) ? 1 : 0);
   endtask

   task automatic run_c(input logic [1:0] g);
      int idx = 0;
      int done_edge = 0;
      int nerr = $countones(g ^ spec_c);
      gate_c = g;
      @(negedge clk); ifc.start = 1'b1;
      @(negedge clk); ifc.start = 1'b0;
      for (int e = 1; e <= 100 && done_edge == 0; e++) begin
         @(negedge clk);
         if (ifc.sample_valid) begin
            chk("c_spat", ifc.sample_pat, idx);
            chk("c_sz", ifc.sample_z, g[idx[0]]);
            idx++;
         end
         if (ifc.done) done_edge = e + 1;
      end
      chk("c_done_edge", done_edge, 1 + 2 * (3 + 1));
      chk("c_strobes", idx, 2);
      chk("c_err_count", ifc.err_count, sat(nerr, 3));
      chk("c_pass", ifc.pass, (nerr == 0) ? 1 : 0);
   endtask

   initial begin
      rst_n = 1'b0;
      ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
      gate_a = 4'b1001; gate_b = 4'b1001; gate_c = 2'b01;
      repeat (3) @(negedge clk);
      chk("rst_a", {ifa.dut_in, ifa.busy, ifa.done, ifa.pass, ifa.err_count,
                    ifa.sample_valid, ifa.sample_pat, ifa.sample_z, ifa.sample_err}, 0);
      chk("rst_b", {ifb.dut_in, ifb.busy, ifb.done, ifb.pass, ifb.err_count, ifb.sample_valid}, 0);
      chk("rst_c", {ifc.dut_in, ifc.busy, ifc.done, ifc.pass, ifc.err_count, ifc.sample_valid}, 0);
      rst_n = 1'b1;

      // Good XNOR2, then z stuck at 0.
      run_a(4'b1001, 0, 1'b0, 0);
      run_a(4'b0000, 0, 1'b0, 0);

      // Reset during pattern 2 settle, then a clean run from scratch.
      run_a(4'b1001, 0, 1'b0, 22);
      @(negedge clk);
      chk("a_in_reset", {ifa.busy, ifa.done, ifa.err_count}, 0);
      rst_n = 1'b1;
      run_a(4'b1001, 0, 1'b0, 0);

      // Starts while busy and during the final sample are ignored; each run starts from DONE.
      for (int i = 0; i < 4; i++)
         run_a(4'($urandom), int'($urandom_range(34, 1)), 1'b1, 0);

      // ERR_W=1 with an inverted gate saturates at 1; then a random gate.
      run_b(4'b0110);
      run_b(4'($urandom));

      // Single-input inverter target.
      run_c(2'b01);
      run_c(2'b10);
      run_c(2'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
